// File: rtl/write_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// write_xfer_ctrl
//
// Drains 8-bit result pixels from a ready/valid result buffer, packs them
// little-endian into 32-bit words (first pixel in bits [7:0]) and writes each
// word to memory at consecutive word addresses starting from base_addr.
//
// Build option:
//   PARTIAL_FLUSH_EN  defined   : a trailing group of 1-3 pixels is written as
//                                 one word with the unused upper lanes zero.
//                     undefined : the pixel count is rounded down to a
//                                 multiple of 4; trailing pixels are neither
//                                 accepted nor written.
//
// Ports:
//   clk                      in   sole clock, rising edge
//   rst                      in   asynchronous active-high reset
//   start_write              in   one-cycle start request (honoured in IDLE only)
//   base_addr[15:0]          in   byte address of the first word (sampled on start)
//   pixel_count[15:0]        in   number of pixels to drain (sampled on start)
//   result_valid             in   result buffer presents a pixel
//   result_data[7:0]         in   result pixel
//   result_ready             out  pixel taken when result_valid & result_ready
//   mem_write                out  memory write request
//   mem_addr[15:0]           out  word-aligned byte address of the write
//   mem_wdata[31:0]          out  packed write data
//   mem_ready                in   memory takes the write when mem_write & mem_ready
//   busy                     out  high from accepted start until completion
//   transfer_data_complete_w out  one-cycle pulse once every word is written
//
// All outputs are driven straight from flops loaded from the next-state
// values, so they are glitch-free and clear the instant rst rises.
// ---------------------------------------------------------------------------
module write_xfer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_write,
  input  logic [15:0] base_addr,
  input  logic [15:0] pixel_count,
  input  logic        result_valid,
  input  logic [7:0]  result_data,
  output logic        result_ready,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        transfer_data_complete_w
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of pixels actually drained for a requested count.
  function automatic logic [15:0] effective_count(input logic [15:0] count);
`ifdef PARTIAL_FLUSH_EN
    return count;
`else
    return {count[15:2], 2'b00};
`endif
  endfunction

  // Place one pixel into the selected byte lane of the packing word.
  function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      default: w[31:24] = data;
    endcase
    return w;
  endfunction

  // Control and datapath state
  logic [1:0]  state_q,     state_d;
  logic [15:0] addr_q,      addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  lane_q,      lane_d;
  logic [31:0] pack_q,      pack_d;
  // An empty transfer spends one extra cycle in DONE before pulsing, so its
  // completion lands two cycles after the start request.
  logic        hold_q,      hold_d;

  // Registered outputs
  logic        result_ready_q, result_ready_d;
  logic        mem_write_q,    mem_write_d;
  logic [15:0] mem_addr_q,     mem_addr_d;
  logic [31:0] mem_wdata_q,    mem_wdata_d;
  logic        busy_q,         busy_d;
  logic        complete_q,     complete_d;

  logic [15:0] start_count_s;

  assign start_count_s = effective_count(pixel_count);

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    hold_d      = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (start_write) begin
          addr_d      = {base_addr[15:2], 2'b00};
          remaining_d = start_count_s;
          lane_d      = 2'd0;
          pack_d      = 32'd0;
          if (start_count_s == 16'd0) begin
            state_d = ST_DONE;
            hold_d  = 1'b1;
          end else begin
            state_d = ST_PACK;
            hold_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PACK: begin
        if (result_valid) begin
          pack_d      = insert_lane(pack_q, lane_q, result_data);
          lane_d      = lane_q + 2'd1;
          remaining_d = remaining_q - 16'd1;
          // A full word, or the final pixel of the transfer, goes out now.
          if ((lane_q == 2'd3) || (remaining_q == 16'd1)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_PACK;
          end
        end else begin
          state_d = ST_PACK;
        end
      end

      ST_WRITE: begin
        if (mem_ready) begin
          addr_d = addr_q + 16'd4;   // wraps modulo 2^16
          pack_d = 32'd0;
          lane_d = 2'd0;
          hold_d = 1'b0;
          if (remaining_q != 16'd0) begin
            state_d = ST_PACK;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_DONE: begin
        if (hold_q) begin
          hold_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        addr_d      = 16'd0;
        remaining_d = 16'd0;
        lane_d      = 2'd0;
        pack_d      = 32'd0;
        hold_d      = 1'b0;
      end
    endcase

    // Outputs for the coming cycle follow the state being entered.
    result_ready_d = (state_d == ST_PACK);
    mem_write_d    = (state_d == ST_WRITE);
    busy_d         = (state_d != ST_IDLE);
    complete_d     = (state_d == ST_DONE) && !hold_d;
    if (state_d == ST_WRITE) begin
      mem_addr_d  = addr_d;
      mem_wdata_d = pack_d;
    end else begin
      mem_addr_d  = 16'd0;
      mem_wdata_d = 32'd0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= 16'd0;
      remaining_q    <= 16'd0;
      lane_q         <= 2'd0;
      pack_q         <= 32'd0;
      hold_q         <= 1'b0;
      result_ready_q <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= 16'd0;
      mem_wdata_q    <= 32'd0;
      busy_q         <= 1'b0;
      complete_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      lane_q         <= lane_d;
      pack_q         <= pack_d;
      hold_q         <= hold_d;
      result_ready_q <= result_ready_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      busy_q         <= busy_d;
      complete_q     <= complete_d;
    end
  end

  assign result_ready             = result_ready_q;
  assign mem_write                = mem_write_q;
  assign mem_addr                 = mem_addr_q;
  assign mem_wdata                = mem_wdata_q;
  assign busy                     = busy_q;
  assign transfer_data_complete_w = complete_q;

endmodule

// File: doc/write_xfer_ctrl.md
WRITE_XFER_CTRL -- requirements
Module: write_xfer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port start_write, input, 1: one-cycle request from main controller to begin draining results.
REQ-004 SHALL have port base_addr, input, 16: byte address of first output word; sampled on accepted start_write.
REQ-005 SHALL have port pixel_count, input, 16: number of 8-bit result pixels to write; sampled on accepted start_write.
REQ-006 SHALL have port result_valid, input, 1: result buffer holds a pixel on result_data.
REQ-007 SHALL have port result_data, input, 8: result pixel.
REQ-008 SHALL have port result_ready, output, 1: pixel accepted when result_valid and result_ready are both high on a clock edge.
REQ-009 SHALL have port mem_write, output, 1: memory write request.
REQ-010 SHALL have port mem_addr, output, 16: word-aligned byte address.
REQ-011 SHALL have port mem_wdata, output, 32: packed write data.
REQ-012 SHALL have port mem_ready, input, 1: memory accepts the write on an edge where mem_write and mem_ready are both high.
REQ-013 SHALL have port busy, output, 1: high from accepted start to completion.
REQ-014 SHALL have port transfer_data_complete_w, output, 1: one-cycle pulse when all words are accepted by memory.

Function
REQ-015 SHALL implement states IDLE, PACK, WRITE, DONE.
REQ-016 IDLE: start_write moves to PACK; loads address register = base_addr, remaining = pixel_count, lane = 0.
REQ-017 start_write SHALL be ignored in any state other than IDLE.
REQ-018 PACK: result_ready = 1; each accepted pixel goes into byte lane `lane` (first pixel in bits [7:0], little-endian); lane increments; remaining decrements.
REQ-019 The 4th pixel of a word, or the last pixel when remaining reaches 0 (per REQ-031/032), SHALL move PACK -> WRITE on the same edge.
REQ-020 WRITE: mem_write = 1, result_ready = 0; mem_addr and mem_wdata SHALL stay stable until mem_ready.
REQ-021 On the mem_ready edge: address += 4, modulo 2^16 wrap, no error; packing register cleared; lane = 0. Then go to PACK if remaining > 0, else DONE.
REQ-022 DONE: transfer_data_complete_w = 1 for exactly one cycle, then IDLE.
REQ-023 pixel_count = 0: IDLE -> DONE directly, with no memory write and no result_ready; pulse arrives 2 cycles after start.
REQ-024 Latency: with result_valid and mem_ready held high, each 4-pixel word SHALL take 5 cycles (4 PACK + 1 WRITE).
REQ-025 result_valid low in PACK SHALL stall without loss; mem_ready low in WRITE SHALL insert wait cycles indefinitely.
REQ-026 busy = 1 in PACK, WRITE, DONE; 0 in IDLE.
REQ-027 result_ready and mem_write SHALL never be high in the same cycle.

Reset
REQ-028 While rst is high, regardless of clk: state = IDLE; all outputs 0; address, remaining, lane and packing register cleared.
REQ-029 rst mid-transfer SHALL abandon the transfer with no completion pulse; the partially packed word is lost.
REQ-030 First accepted start_write after rst deasserts SHALL behave normally.

Configuration
REQ-031 With macro PARTIAL_FLUSH_EN defined: a trailing 1-3 pixels SHALL be written as one word, unused upper lanes zero.
REQ-032 Without PARTIAL_FLUSH_EN: the effective count SHALL be pixel_count rounded down to a multiple of 4; the trailing pixels are neither accepted nor written; a rounded count of 0 follows REQ-023.

Verification
REQ-033 base_addr=0x1000, pixel_count=8, pixels 0x01..0x08, mem_ready=1 -> writes 0x04030201@0x1000 and 0x08070605@0x1004; pulse 11 cycles after start.
REQ-034 pixel_count=4, mem_ready low for 3 cycles -> mem_write held 4 cycles with stable addr/data; exactly one pulse.
REQ-035 base_addr=0xFFFC, pixel_count=8 -> second write to 0x0000.
REQ-036 pixel_count=6, pixels 0xA1..0xA6 -> with PARTIAL_FLUSH_EN, 2nd word 0x0000A6A5; without it, only 0xA4A3A2A1 and result_ready asserted for 4 pixels only.
REQ-037 pixel_count=0 -> no mem_write; pulse 2 cycles after start; start_write pulsed again while busy ignored.
REQ-038 rst asserted during 2nd word's PACK -> outputs 0 immediately, no pulse; next start runs cleanly.
